// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: holding + shift register, start/data/[parity]/stop framing.
// Ports: clk, rst (sync high), baud_tick, tx_data/tx_valid/tx_ready, cfg_*, txd, tx_busy, tx_done. Option: UART_TX_PARITY_EN.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_stop2,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_n;
  logic [CW-1:0]        tick_cnt, tick_n;
  logic [2:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] hold, shift, shift_n;
  logic                 hold_full;
  logic                 stop2_q;
  logic                 txd_n, done_n, load, adv;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_q;
`else
  logic unused_cfg;
  assign unused_cfg = cfg_parity_en ^ cfg_parity_odd;
`endif

  // tx_ready is the flop; hold_full is just its complement
  assign hold_full = ~tx_ready;
  assign tx_busy   = (state != IDLE);
  assign adv       = baud_tick && (tick_cnt == CW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      hold     <= '0;
      shift    <= '0;
      tx_ready <= 1'b1;
      stop2_q  <= 1'b0;
      txd      <= 1'b1;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      txd      <= txd_n;
      tx_done  <= done_n;
      if (load) begin
        tx_ready <= 1'b1;
        stop2_q  <= cfg_stop2;
`ifdef UART_TX_PARITY_EN
        par_en_q <= cfg_parity_en;
        par_q    <= (^hold) ^ cfg_parity_odd;
`endif
      end else if (tx_valid && tx_ready) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    shift_n = shift;
    txd_n   = txd;
    done_n  = 1'b0;
    load    = 1'b0;
    tick_n  = tick_cnt;
    if (baud_tick) tick_n = adv ? '0 : tick_cnt + 1'b1;
    unique case (state)
      IDLE: begin
        txd_n  = 1'b1;
        tick_n = '0;
        if (baud_tick && hold_full) begin
          load    = 1'b1;
          state_n = START;
          txd_n   = 1'b0;
        end
      end
      START: begin
        if (adv) begin
          state_n = DATA;
          bit_n   = '0;
          txd_n   = shift[0];
        end
      end
      DATA: begin
        if (adv) begin
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            bit_n   = '0;
            state_n = STOP;
            txd_n   = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_n = PARITY;
              txd_n   = par_q;
            end
`endif
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = shift >> 1;
            txd_n   = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (adv) begin
          state_n = STOP;
          bit_n   = '0;
          txd_n   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (adv) begin
          // bit_cnt marks the first of two stop bits
          if (stop2_q && bit_cnt == 3'd0) begin
            bit_n = 3'd1;
          end else begin
            done_n = 1'b1;
            bit_n  = '0;
            if (hold_full) begin
              load    = 1'b1;
              state_n = START;
              txd_n   = 1'b0;
            end else begin
              state_n = IDLE;
              txd_n   = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) shift_n = hold;
  end

endmodule
